dpll_loop_ctrl: RTL and testbench

DPLL_LOOP_CTRL -- requirements
Module: dpll_loop_ctrl

---
 rtl/dpll_pkg.sv | 22 ++
 rtl/dpll_lock_window.sv | 72 +++++++
 rtl/dpll_loop_ctrl.sv | 172 +++++++++++++++++
 tb/tb_dpll_loop_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/dpll_pkg.sv
// +-----------------------------------------------------------------------+
// | Package     : dpll_pkg                                                |
// | Description : Shared definitions for the DPLL loop controller: the    |
// |               loop state encoding and the default NCO word width.     |
// | Revision    : 1.0 - initial release                                   |
// +-----------------------------------------------------------------------+
`default_nettype none

package dpll_pkg;

   localparam int FW_W_DEF = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_ACQ   = 2'b01,
      ST_TRACK = 2'b10,
      ST_HOLD  = 2'b11
   } dpll_state_t;

endpackage

`default_nettype wire

// File: rtl/dpll_lock_window.sv
// +-----------------------------------------------------------------------+
// | Module      : dpll_lock_window                                        |
// | Description : Lock qualifier. Counts phase events into windows of     |
// |               LOCK_WIN events while summing their signs; flags each   |
// |               closing event and whether its window was good, and      |
// |               keeps a saturating count of consecutive good windows.   |
// | Ports       : clk, reset     - clock, async active-high reset         |
// |               clear          - drop partial window and good count     |
// |               event_in       - a phase event is present this cycle    |
// |               sign_neg       - sign of that event (1 = negative)      |
// |               window_done    - this event closes the window (comb)    |
// |               window_good    - closing window |sum| <= LOCK_TOL (comb)|
// |               good_count     - consecutive good windows (registered)  |
// | Revision    : 1.0 - initial release                                   |
// +-----------------------------------------------------------------------+
`default_nettype none

module dpll_lock_window
   import dpll_pkg::*;
#(
   parameter int LOCK_WIN     = 16,
   parameter int LOCK_TOL     = 4,
   parameter int LOCK_CONFIRM = 2
)(
   input  logic       clk,
   input  logic       reset,
   input  logic       clear,
   input  logic       event_in,
   input  logic       sign_neg,
   output logic       window_done,
   output logic       window_good,
   output logic [7:0] good_count
);

   logic        [15:0] cnt;
   logic signed [15:0] sum;
   logic signed [15:0] sum_n;
   logic        [15:0] abs_sum;

   // The closing event's own sign belongs to the window it closes.
   assign sum_n       = sign_neg ? (sum - 16'sd1) : (sum + 16'sd1);
   assign abs_sum     = sum_n[15] ? 16'(-sum_n) : 16'(sum_n);
   assign window_done = event_in && (cnt == 16'(LOCK_WIN - 1));
   assign window_good = (abs_sum <= 16'(LOCK_TOL));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt        <= '0;
         sum        <= '0;
         good_count <= '0;
      end else if (clear) begin
         cnt        <= '0;
         sum        <= '0;
         good_count <= '0;
      end else if (event_in) begin
         if (window_done) begin
            cnt <= '0;
            sum <= '0;
            if (!window_good)
               good_count <= '0;
            else if (good_count < 8'(LOCK_CONFIRM))
               good_count <= good_count + 8'd1;
         end else begin
            cnt <= cnt + 16'd1;
            sum <= sum_n;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/dpll_loop_ctrl.sv
// +-----------------------------------------------------------------------+
// | Module      : dpll_loop_ctrl                                          |
// | Description : Bang-bang DPLL loop filter and lock controller. Each    |
// |               phase event steps a saturating integrator and sets a    |
// |               proportional term, with gains chosen by loop state      |
// |               (ACQUIRE / TRACK); freq_word = F_NOM + integ + prop.    |
// | Build macro : DPLL_LOOP_CTRL_HOLDOVER_EN - adds HOLD state entered    |
// |               after HOLD_TIMEOUT event-free cycles in TRACK.          |
// | Ports       : clk, reset     - clock, async active-high reset         |
// |               enable         - loop run request                       |
// |               phase_error    - signed detector output, 0 = no event   |
// |               freq_word      - registered NCO tuning word             |
// |               locked         - high in TRACK / HOLD                   |
// |               state          - 00 IDLE 01 ACQ 10 TRACK 11 HOLD        |
// |               integ          - integral accumulator (observation)     |
// | Revision    : 1.0 - initial release                                   |
// +-----------------------------------------------------------------------+
`default_nettype none

module dpll_loop_ctrl
   import dpll_pkg::*;
#(
   parameter int              FW_W         = FW_W_DEF,
   parameter logic [FW_W-1:0] F_NOM        = 32'h0147_AE14,
   parameter int              KP_ACQ       = 4096,
   parameter int              KI_ACQ       = 256,
   parameter int              KP_TRK       = 256,
   parameter int              KI_TRK       = 4,
   parameter int              INTEG_LIM    = 1048576,
   parameter int              LOCK_WIN     = 16,
   parameter int              LOCK_TOL     = 4,
   parameter int              LOCK_CONFIRM = 2,
   parameter int              HOLD_TIMEOUT = 65535
)(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enable,
   input  logic signed [15:0]     phase_error,
   output logic [FW_W-1:0]        freq_word,
   output logic                   locked,
   output logic [1:0]             state,
   output logic signed [FW_W-1:0] integ
);

   localparam logic signed [FW_W-1:0] LIM = FW_W'(INTEG_LIM);

   dpll_state_t            st_q, st_n;
   logic signed [FW_W-1:0] prop_q, prop_n, integ_n;
   logic [FW_W-1:0]        fw_n;
   logic signed [FW_W-1:0] kp, ki, step_i, prop_ev, integ_sum, integ_sat;
   logic                   evt, neg, run;
   logic                   win_done, win_good, confirm;
   logic [7:0]             good_count;

`ifdef DPLL_LOOP_CTRL_HOLDOVER_EN
   logic [31:0]            idle_q, idle_n;
`endif

   assign evt   = (phase_error != 16'sd0);
   assign neg   = phase_error[15];
   assign run   = (st_q == ST_ACQ) || (st_q == ST_TRACK);
   assign state = st_q;

   // Gains follow the state in force when the event arrives, so a gain
   // change takes effect from the first event after a transition.
   assign kp        = (st_q == ST_TRACK) ? FW_W'(KP_TRK) : FW_W'(KP_ACQ);
   assign ki        = (st_q == ST_TRACK) ? FW_W'(KI_TRK) : FW_W'(KI_ACQ);
   assign step_i    = neg ? -ki : ki;
   assign prop_ev   = neg ? -kp : kp;
   assign integ_sum = integ + step_i;
   assign integ_sat = (integ_sum > LIM)  ? LIM  :
                      (integ_sum < -LIM) ? -LIM : integ_sum;

   // The closing event of the LOCK_CONFIRM-th good window triggers TRACK.
   assign confirm = (int'(good_count) + 1) >= LOCK_CONFIRM;

   dpll_lock_window #(
      .LOCK_WIN     (LOCK_WIN),
      .LOCK_TOL     (LOCK_TOL),
      .LOCK_CONFIRM (LOCK_CONFIRM)
   ) u_lock_window (
      .clk         (clk),
      .reset       (reset),
      .clear       (!enable || !run),
      .event_in    (evt && run),
      .sign_neg    (neg),
      .window_done (win_done),
      .window_good (win_good),
      .good_count  (good_count)
   );

   always_comb begin
      st_n    = st_q;
      integ_n = integ;
      prop_n  = prop_q;
      fw_n    = freq_word;
`ifdef DPLL_LOOP_CTRL_HOLDOVER_EN
      idle_n  = '0;
`endif
      if (!enable) begin
         st_n    = ST_IDLE;
         integ_n = '0;
         prop_n  = '0;
         fw_n    = F_NOM;
      end else begin
         case (st_q)
            ST_IDLE: begin
               st_n    = ST_ACQ;
               integ_n = '0;
               prop_n  = '0;
               fw_n    = F_NOM;
            end
            ST_ACQ, ST_TRACK: begin
               if (evt) begin
                  integ_n = integ_sat;
                  prop_n  = prop_ev;
                  fw_n    = F_NOM + FW_W'($unsigned(integ_sat)) + FW_W'($unsigned(prop_ev));
               end
               if (st_q == ST_ACQ) begin
                  if (win_done && win_good && confirm)
                     st_n = ST_TRACK;
               end else if (win_done && !win_good) begin
                  st_n = ST_ACQ;
               end
`ifdef DPLL_LOOP_CTRL_HOLDOVER_EN
               else if (!evt) begin
                  if (idle_q == 32'(HOLD_TIMEOUT - 1))
                     st_n = ST_HOLD;
                  else
                     idle_n = idle_q + 32'd1;
               end
`endif
            end
`ifdef DPLL_LOOP_CTRL_HOLDOVER_EN
            ST_HOLD: begin
               // freq_word and integ stay frozen; the waking event only
               // re-enters ACQUIRE and is not integrated.
               prop_n = '0;
               if (evt)
                  st_n = ST_ACQ;
            end
`endif
            default: st_n = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st_q      <= ST_IDLE;
         locked    <= 1'b0;
         integ     <= '0;
         prop_q    <= '0;
         freq_word <= F_NOM;
`ifdef DPLL_LOOP_CTRL_HOLDOVER_EN
         idle_q    <= '0;
`endif
      end else begin
         st_q      <= st_n;
         locked    <= (st_n == ST_TRACK) || (st_n == ST_HOLD);
         integ     <= integ_n;
         prop_q    <= prop_n;
         freq_word <= fw_n;
`ifdef DPLL_LOOP_CTRL_HOLDOVER_EN
         idle_q    <= idle_n;
`endif
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_dpll_loop_ctrl.sv
// +-----------------------------------------------------------------------+
// | Module      : tb_dpll_loop_ctrl                                       |
// | Description : Directed self-checking bench for dpll_loop_ctrl with    |
// |               default parameters (holdover disabled).                 |
// | Revision    : 1.0 - initial release                                   |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_dpll_loop_ctrl;

   localparam logic [31:0] FNOM = 32'h0147_AE14;

   logic               clk = 1'b0;
   logic               reset;
   logic               enable;
   logic signed [15:0] phase_error;
   logic [31:0]        freq_word;
   logic               locked;
   logic [1:0]         state;
   logic signed [31:0] integ;

   int n_checks = 0;
   int n_fail   = 0;

   dpll_loop_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .phase_error (phase_error),
      .freq_word   (freq_word),
      .locked      (locked),
      .state       (state),
      .integ       (integ)
   );

   always #10 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One clock with the given phase_error; outputs sampled 1 time unit later.
   task automatic tick(input int pe);
      phase_error = 16'(pe);
      @(posedge clk);
      #1;
   endtask

   // Window of np positive events followed by nn negative events.
   task automatic window(input int np, input int nn);
      for (int i = 0; i < np; i++) tick(1);
      for (int i = 0; i < nn; i++) tick(-1);
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; phase_error = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_state",  32'(state),  32'd0);
      check("rst_fw",     freq_word,   FNOM);
      check("rst_integ",  integ,       32'd0);
      check("rst_locked", 32'(locked), 32'd0);

      // Enable with no events
      reset = 1'b0; enable = 1'b1;
      tick(0);
      check("en_state",  32'(state),  32'd1);
      check("en_fw",     freq_word,   FNOM);
      check("en_locked", 32'(locked), 32'd0);
      tick(0);
      check("en_fw2",    freq_word,   FNOM);

      // Single +1 event in ACQUIRE
      tick(1);
      check("ev1_integ", integ,     32'd256);
      check("ev1_fw",    freq_word, FNOM + 32'd256 + 32'd4096);
      tick(0);

      // enable low clears, then back to ACQUIRE with a fresh window
      enable = 1'b0;
      tick(0);
      check("dis_state", 32'(state), 32'd0);
      check("dis_integ", integ,      32'd0);
      enable = 1'b1;
      tick(0);
      check("reen_state", 32'(state), 32'd1);

      // 32 alternating events: two good windows -> TRACK
      for (int i = 0; i < 16; i++) tick((i % 2 == 0) ? 1 : -1);
      check("win1_state", 32'(state), 32'd1);
      for (int i = 0; i < 15; i++) tick((i % 2 == 0) ? 1 : -1);
      check("pre_lock_state", 32'(state), 32'd1);
      tick(-1);
      check("lock_state",  32'(state),  32'd2);
      check("lock_locked", 32'(locked), 32'd1);
      check("lock_integ",  integ,       32'd0);
      check("lock_fw",     freq_word,   FNOM - 32'd4096);
      tick(0);

      // 16 +1 events in TRACK use TRACK gains; bad window -> ACQUIRE
      for (int i = 0; i < 15; i++) tick(1);
      check("trk_state", 32'(state), 32'd2);
      tick(1);
      check("unlock_state",  32'(state),  32'd1);
      check("unlock_locked", 32'(locked), 32'd0);
      check("unlock_integ",  integ,       32'd64);
      check("unlock_fw",     freq_word,   FNOM + 32'd64 + 32'd256);
      tick(1);
      check("acq_gain_integ", integ,     32'd320);
      check("acq_gain_fw",    freq_word, FNOM + 32'd320 + 32'd4096);

      // Saturation: 5000 +1 events
      for (int i = 0; i < 5000; i++) tick(1);
      check("sat_integ", integ,      32'd1048576);
      check("sat_fw",    freq_word,  FNOM + 32'd1048576 + 32'd4096);
      check("sat_state", 32'(state), 32'd1);
      tick(1);
      check("sat_fw_hold", freq_word, FNOM + 32'd1048576 + 32'd4096);
      // Non-unit magnitudes count by sign only
      tick(-5);
      check("neg_integ", integ,     32'd1048320);
      check("neg_fw",    freq_word, FNOM + 32'd1048320 - 32'd4096);
      tick(7);
      check("pos7_integ", integ, 32'd1048576);
      tick(0);

      // Tolerance boundary: sum 4 good, sum 6 bad (clears good count)
      enable = 1'b0; tick(0);
      enable = 1'b1; tick(0);
      window(10, 6);
      window(11, 5);
      window(10, 6);
      check("tol_bad_state", 32'(state), 32'd1);
      window(10, 6);
      check("tol_lock_state", 32'(state), 32'd2);

      // enable dropped in TRACK with a simultaneous event
      enable = 1'b0;
      tick(1);
      check("drop_state",  32'(state),  32'd0);
      check("drop_integ",  integ,       32'd0);
      check("drop_fw",     freq_word,   FNOM);
      check("drop_locked", 32'(locked), 32'd0);

      // Reset mid-window discards partial accumulation
      enable = 1'b1; tick(0);
      for (int i = 0; i < 5; i++) tick((i % 2 == 0) ? 1 : -1);
      phase_error = '0;
      #4 reset = 1'b1;
      #2;
      check("arst_state", 32'(state), 32'd0);
      check("arst_integ", integ,      32'd0);
      check("arst_fw",    freq_word,  FNOM);
      @(posedge clk); #1;
      reset = 1'b0;
      tick(0);
      check("post_rst_state", 32'(state), 32'd1);
      for (int i = 0; i < 31; i++) tick((i % 2 == 0) ? 1 : -1);
      check("post_rst_31", 32'(state), 32'd1);
      tick(-1);
      check("post_rst_32", 32'(state), 32'd2);
      tick(0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
